// File: rtl/mdio_slave_22_45_frontend_os.sv
// mdio_slave_22_45_frontend_os
// Oversampled MDIO slave frontend for Clause 22 / Clause 45 frames. MDC and
// MDIO are synchronised into clk_25m and every bit is sampled on a detected
// MDC rise. Header decode, TA drive, read data shifting and write capture
// happen here; the register map sits behind the req_*/resp_* handshake.
//
// Ports:
//   clk_25m, rst, enable          clock, sync active-high reset, sync clear
//   mdc, mdio_in                  asynchronous pad inputs
//   mdio_out, mdio_oe             pad drive (open-drain gating optional)
//   opendrain_mode, c45_en        drive style, accept ST=00 frames
//   phy_addr, phy_addr_mask       masked PHY address match
//   broadcast_mode/_addr          additional broadcast address match
//   hdr_valid, wr_valid           1-cycle pulses: read header, write done
//   req_c45/op/phyad/regad/wdata  request fields, held until next header
//   resp_rdata, resp_valid        read response from backend
//   frame_err                     1-cycle pulse: timeout, late resp, bad ST
//   legal                         address match of current/last frame
module mdio_slave_22_45_frontend_os #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRE_MIN     = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic        enable,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        opendrain_mode,
    input  logic        c45_en,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  phy_addr_mask,
    input  logic        broadcast_mode,
    input  logic [4:0]  broadcast_addr,
    output logic        hdr_valid,
    output logic        wr_valid,
    output logic        req_c45,
    output logic [1:0]  req_op,
    output logic [4:0]  req_phyad,
    output logic [4:0]  req_regad,
    output logic [15:0] req_wdata,
    input  logic [15:0] resp_rdata,
    input  logic        resp_valid,
    output logic        frame_err,
    output logic        legal
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_TA, S_WDATA, S_RDATA} state_t;

    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [5:0]         PRE_MIN_V = 6'(PRE_MIN);
    localparam logic [STALL_W-1:0] TIMEOUT_V = STALL_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
    logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
    logic                   mdc_dly_q, mdc_dly_d;

    state_t               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [5:0]           pre_cnt_q, pre_cnt_d;
    logic [12:0]          hdr_sr_q, hdr_sr_d;
    logic [15:0]          dat_sr_q, dat_sr_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 rd_frame_q, rd_frame_d;
    logic                 wr_frame_q, wr_frame_d;
    logic                 resp_ok_q, resp_ok_d;
    logic [15:0]          resp_buf_q, resp_buf_d;
    logic                 mdio_out_q, mdio_out_d;
    logic                 oe_q, oe_d;
    logic                 hdr_valid_q, hdr_valid_d;
    logic                 wr_valid_q, wr_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 legal_q, legal_d;
    logic                 req_c45_q, req_c45_d;
    logic [1:0]           req_op_q, req_op_d;
    logic [4:0]           req_phyad_q, req_phyad_d;
    logic [4:0]           req_regad_q, req_regad_d;
    logic [15:0]          req_wdata_q, req_wdata_d;

    logic                 mdc_s, mdio_s, rise;
    logic [13:0]          hdr_word;
    logic                 is_c22, is_c45, st_ok, addr_ok, is_rd, is_wr;
    logic [15:0]          rd_load;
    logic [STALL_W-1:0]   stall_inc;

    assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
    assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
    assign rise   = mdc_s & ~mdc_dly_q;

    // Full header including the bit being sampled on this rise.
    assign hdr_word = {hdr_sr_q, mdio_s};
    assign is_c22   = (hdr_word[13:12] == 2'b01);
    assign is_c45   = (hdr_word[13:12] == 2'b00) & c45_en;
    assign st_ok    = is_c22 | is_c45;
    assign addr_ok  = ((hdr_word[9:5] & phy_addr_mask) == (phy_addr & phy_addr_mask)) |
                      (broadcast_mode & (hdr_word[9:5] == broadcast_addr));
    // C45 reads are OP=11 (read) and OP=10 (post-read-increment).
    assign is_rd    = is_c22 ? (hdr_word[11:10] == 2'b10) : hdr_word[11];
    assign is_wr    = is_c22 ? (hdr_word[11:10] == 2'b01) : ~hdr_word[11];

    // A response arriving on the bit-15 rise itself is still on time.
    assign rd_load   = resp_valid ? resp_rdata : (resp_ok_q ? resp_buf_q : 16'hFFFF);
    assign stall_inc = stall_q + 1'b1;

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
        mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
        mdc_dly_d   = mdc_s;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        hdr_sr_d    = hdr_sr_q;
        dat_sr_d    = dat_sr_q;
        stall_d     = '0;
        rd_frame_d  = rd_frame_q;
        wr_frame_d  = wr_frame_q;
        resp_ok_d   = resp_ok_q;
        resp_buf_d  = resp_buf_q;
        mdio_out_d  = mdio_out_q;
        oe_d        = oe_q;
        hdr_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        legal_d     = legal_q;
        req_c45_d   = req_c45_q;
        req_op_d    = req_op_q;
        req_phyad_d = req_phyad_q;
        req_regad_d = req_regad_q;
        req_wdata_d = req_wdata_q;

        if (state_q != S_IDLE) begin
            pre_cnt_d = '0;
            stall_d   = rise ? '0 : stall_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    if (mdio_s) begin
                        if (pre_cnt_q < 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= PRE_MIN_V) begin
                        state_d   = S_HDR;
                        bit_cnt_d = 5'd1;
                        hdr_sr_d  = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
            end
            S_HDR: begin
                if (rise) begin
                    hdr_sr_d  = hdr_word[12:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd13) begin
                        state_d     = S_TA;
                        legal_d     = st_ok & addr_ok;
                        rd_frame_d  = st_ok & addr_ok & is_rd;
                        wr_frame_d  = st_ok & addr_ok & is_wr;
                        resp_ok_d   = 1'b0;
                        frame_err_d = ~st_ok;
                        hdr_valid_d = st_ok & addr_ok & is_rd;
                        if (st_ok & addr_ok) begin
                            req_c45_d   = is_c45;
                            req_op_d    = hdr_word[11:10];
                            req_phyad_d = hdr_word[9:5];
                            req_regad_d = hdr_word[4:0];
                        end
                    end
                end
            end
            S_TA: begin
                if (rd_frame_q && resp_valid) begin
                    resp_ok_d  = 1'b1;
                    resp_buf_d = resp_rdata;
                end
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd14) begin
                        if (rd_frame_q) begin
                            oe_d       = 1'b1;
                            mdio_out_d = 1'b0;
                        end
                    end else if (rd_frame_q) begin
                        state_d     = S_RDATA;
                        mdio_out_d  = rd_load[15];
                        dat_sr_d    = {rd_load[14:0], 1'b0};
                        frame_err_d = ~resp_valid & ~resp_ok_q;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    dat_sr_d  = {dat_sr_q[14:0], mdio_s};
                    if (bit_cnt_q == 5'd31) begin
                        state_d = S_IDLE;
                        if (wr_frame_q) begin
                            wr_valid_d  = 1'b1;
                            req_wdata_d = {dat_sr_q[14:0], mdio_s};
                        end
                    end
                end
            end
            S_RDATA: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        state_d    = S_IDLE;
                        oe_d       = 1'b0;
                        mdio_out_d = 1'b1;
                    end else begin
                        mdio_out_d = dat_sr_q[15];
                        dat_sr_d   = {dat_sr_q[14:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // MDC stall abort; a rise in the same cycle takes precedence.
        if ((state_q != S_IDLE) && !rise && (stall_inc == TIMEOUT_V)) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            stall_d     = '0;
            oe_d        = 1'b0;
            mdio_out_d  = 1'b1;
            frame_err_d = 1'b1;
            hdr_valid_d = 1'b0;
            wr_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst || !enable) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            mdc_dly_q   <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            hdr_sr_q    <= '0;
            dat_sr_q    <= '0;
            stall_q     <= '0;
            rd_frame_q  <= 1'b0;
            wr_frame_q  <= 1'b0;
            resp_ok_q   <= 1'b0;
            resp_buf_q  <= '0;
            mdio_out_q  <= 1'b1;
            oe_q        <= 1'b0;
            hdr_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            legal_q     <= 1'b0;
            req_c45_q   <= 1'b0;
            req_op_q    <= '0;
            req_phyad_q <= '0;
            req_regad_q <= '0;
            req_wdata_q <= '0;
        end else begin
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            mdc_dly_q   <= mdc_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            hdr_sr_q    <= hdr_sr_d;
            dat_sr_q    <= dat_sr_d;
            stall_q     <= stall_d;
            rd_frame_q  <= rd_frame_d;
            wr_frame_q  <= wr_frame_d;
            resp_ok_q   <= resp_ok_d;
            resp_buf_q  <= resp_buf_d;
            mdio_out_q  <= mdio_out_d;
            oe_q        <= oe_d;
            hdr_valid_q <= hdr_valid_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            legal_q     <= legal_d;
            req_c45_q   <= req_c45_d;
            req_op_q    <= req_op_d;
            req_phyad_q <= req_phyad_d;
            req_regad_q <= req_regad_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oe   = oe_q & ~(opendrain_mode & mdio_out_q);
    assign hdr_valid = hdr_valid_q;
    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign legal     = legal_q;
    assign req_c45   = req_c45_q;
    assign req_op    = req_op_q;
    assign req_phyad = req_phyad_q;
    assign req_regad = req_regad_q;
    assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_mdio_slave_22_45_frontend_os.sv
// Testbench for mdio_slave_22_45_frontend_os: a vector table of whole MDIO
// frames plus hand-written sequences for open-drain, reset mid-frame, MDC
// stall timeout and short preamble.
module tb_mdio_slave_22_45_frontend_os;

    localparam int unsigned TO_CYC = 64;

    logic        clk_25m = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdio_out, mdio_oe;
    logic        opendrain_mode = 1'b0;
    logic        c45_en = 1'b0;
    logic [4:0]  phy_addr = 5'h05;
    logic [4:0]  phy_addr_mask = 5'h1F;
    logic        broadcast_mode = 1'b0;
    logic [4:0]  broadcast_addr = 5'h1F;
    logic        hdr_valid, wr_valid, frame_err, legal, req_c45;
    logic [1:0]  req_op;
    logic [4:0]  req_phyad, req_regad;
    logic [15:0] req_wdata;
    logic [15:0] resp_rdata = '0;
    logic        resp_valid = 1'b0;

    mdio_slave_22_45_frontend_os #(
        .SYNC_STAGES(2),
        .PRE_MIN(32),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_25m(clk_25m), .rst(rst), .enable(enable), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .opendrain_mode(opendrain_mode),
        .c45_en(c45_en), .phy_addr(phy_addr), .phy_addr_mask(phy_addr_mask),
        .broadcast_mode(broadcast_mode), .broadcast_addr(broadcast_addr),
        .hdr_valid(hdr_valid), .wr_valid(wr_valid), .req_c45(req_c45), .req_op(req_op),
        .req_phyad(req_phyad), .req_regad(req_regad), .req_wdata(req_wdata),
        .resp_rdata(resp_rdata), .resp_valid(resp_valid), .frame_err(frame_err),
        .legal(legal)
    );

    always #20 clk_25m = ~clk_25m;

    int n_chk = 0;
    int n_fail = 0;
    int n_hdr = 0, n_wr = 0, n_err = 0, n_oe = 0;
    logic [31:0] s_out, s_oe;
    logic        resp_en = 1'b0;
    logic [15:0] resp_data = '0;

    always @(negedge clk_25m) begin
        if (hdr_valid) n_hdr++;
        if (wr_valid)  n_wr++;
        if (frame_err) n_err++;
        if (mdio_oe)   n_oe++;
    end

    // Backend model: answer 5 cycles after each hdr_valid when enabled.
    initial begin
        forever begin
            @(negedge clk_25m);
            if (hdr_valid && resp_en) begin
                repeat (5) @(negedge clk_25m);
                resp_rdata = resp_data;
                resp_valid = 1'b1;
                @(negedge clk_25m);
                resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One MDC period: data set while MDC low, slave output sampled just
    // before the rise that would capture it on the master side.
    task automatic mdc_bit(input logic b, input int k);
        mdio_in = b;
        repeat (10) @(negedge clk_25m);
        if (k >= 0) begin
            s_out[k] = mdio_out;
            s_oe[k]  = mdio_oe;
        end
        mdc = 1'b1;
        repeat (10) @(negedge clk_25m);
        mdc = 1'b0;
    endtask

    task automatic send_frame(input int npre, input logic [31:0] fr, input int nbits,
                              input logic is_rd);
        s_out = '1;
        s_oe  = '0;
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, -1);
        for (int k = 0; k < nbits; k++) mdc_bit((is_rd && k >= 14) ? 1'b1 : fr[31-k], k);
        mdio_in = 1'b1;
    endtask

    function automatic logic [15:0] rd_bits(input logic [31:0] s);
        logic [15:0] r;
        for (int k = 16; k < 32; k++) r[31-k] = s[k];
        return r;
    endfunction

    typedef struct {
        logic        c45en;
        logic        bmode;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wd;
        logic        is_rd;
        logic        resp;
        logic [15:0] rd;
        int          e_hdr;
        int          e_wr;
        int          e_err;
        logic        e_legal;
        logic        e_c45;
        logic [1:0]  e_op;
        logic [4:0]  e_phy;
        logic [4:0]  e_reg;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
        logic        e_oe;
    } vec_t;

    vec_t tv [11];

    task automatic run_vec(input int idx, input vec_t v);
        int h0, w0, e0, o0;
        c45_en = v.c45en;
        broadcast_mode = v.bmode;
        resp_en = v.resp;
        resp_data = v.rd;
        h0 = n_hdr; w0 = n_wr; e0 = n_err; o0 = n_oe;
        send_frame(32, {v.st, v.op, v.phy, v.regad, 2'b10, v.wd}, 32, v.is_rd);
        repeat (5) @(negedge clk_25m);
        chk($sformatf("v%0d hdr_cnt", idx), n_hdr - h0, v.e_hdr);
        chk($sformatf("v%0d wr_cnt", idx), n_wr - w0, v.e_wr);
        chk($sformatf("v%0d err_cnt", idx), n_err - e0, v.e_err);
        chk($sformatf("v%0d legal", idx), 32'(legal), 32'(v.e_legal));
        chk($sformatf("v%0d req_c45", idx), 32'(req_c45), 32'(v.e_c45));
        chk($sformatf("v%0d req_op", idx), 32'(req_op), 32'(v.e_op));
        chk($sformatf("v%0d req_phyad", idx), 32'(req_phyad), 32'(v.e_phy));
        chk($sformatf("v%0d req_regad", idx), 32'(req_regad), 32'(v.e_reg));
        chk($sformatf("v%0d req_wdata", idx), 32'(req_wdata), 32'(v.e_wdata));
        chk($sformatf("v%0d oe_seen", idx), 32'(n_oe > o0), 32'(v.e_oe));
        chk($sformatf("v%0d oe_end", idx), 32'(mdio_oe), 32'd0);
        if (v.e_oe) begin
            chk($sformatf("v%0d ta1_oe", idx), 32'(s_oe[14]), 32'd0);
            chk($sformatf("v%0d ta2_oe", idx), 32'(s_oe[15]), 32'd1);
            chk($sformatf("v%0d ta2_out", idx), 32'(s_out[15]), 32'd0);
            chk($sformatf("v%0d rdata", idx), 32'(rd_bits(s_out)), 32'(v.e_rdata));
        end
    endtask

    initial begin
        int h0, w0, e0, o0, cyc;
        logic seen;

        //        c45 bm  st     op     phy    reg    wd        rd  rsp rdata     hdr wr err lgl c45 op     phy    reg    wdata     rdata     oe
        tv[0]  = '{0,  0, 2'b01, 2'b01, 5'h05, 5'h03, 16'hA55A, 0,  0, 16'h0000, 0,  1, 0,  1,  0, 2'b01, 5'h05, 5'h03, 16'hA55A, 16'h0000, 0};
        tv[1]  = '{0,  0, 2'b01, 2'b10, 5'h05, 5'h02, 16'h0000, 1,  1, 16'h1234, 1,  0, 0,  1,  0, 2'b10, 5'h05, 5'h02, 16'hA55A, 16'h1234, 1};
        tv[2]  = '{1,  0, 2'b00, 2'b00, 5'h05, 5'h01, 16'h0010, 0,  0, 16'h0000, 0,  1, 0,  1,  1, 2'b00, 5'h05, 5'h01, 16'h0010, 16'h0000, 0};
        tv[3]  = '{1,  0, 2'b00, 2'b11, 5'h05, 5'h01, 16'h0000, 1,  1, 16'hBEEF, 1,  0, 0,  1,  1, 2'b11, 5'h05, 5'h01, 16'h0010, 16'hBEEF, 1};
        tv[4]  = '{0,  0, 2'b00, 2'b00, 5'h05, 5'h01, 16'h0010, 0,  0, 16'h0000, 0,  0, 1,  0,  1, 2'b11, 5'h05, 5'h01, 16'h0010, 16'h0000, 0};
        tv[5]  = '{0,  0, 2'b00, 2'b11, 5'h05, 5'h01, 16'h0000, 1,  1, 16'hBEEF, 0,  0, 1,  0,  1, 2'b11, 5'h05, 5'h01, 16'h0010, 16'h0000, 0};
        tv[6]  = '{0,  0, 2'b01, 2'b10, 5'h05, 5'h07, 16'h0000, 1,  0, 16'h0000, 1,  0, 1,  1,  0, 2'b10, 5'h05, 5'h07, 16'h0010, 16'hFFFF, 1};
        tv[7]  = '{0,  1, 2'b01, 2'b10, 5'h1F, 5'h04, 16'h0000, 1,  1, 16'h5A5A, 1,  0, 0,  1,  0, 2'b10, 5'h1F, 5'h04, 16'h0010, 16'h5A5A, 1};
        tv[8]  = '{0,  0, 2'b01, 2'b10, 5'h1F, 5'h09, 16'h0000, 1,  1, 16'h5A5A, 0,  0, 0,  0,  0, 2'b10, 5'h1F, 5'h04, 16'h0010, 16'h0000, 0};
        tv[9]  = '{0,  0, 2'b01, 2'b01, 5'h06, 5'h03, 16'hFFFF, 0,  0, 16'h0000, 0,  0, 0,  0,  0, 2'b10, 5'h1F, 5'h04, 16'h0010, 16'h0000, 0};
        tv[10] = '{1,  0, 2'b00, 2'b10, 5'h05, 5'h03, 16'h0000, 1,  1, 16'h8001, 1,  0, 0,  1,  1, 2'b10, 5'h05, 5'h03, 16'h0010, 16'h8001, 1};

        repeat (4) @(negedge clk_25m);
        rst = 1'b0;
        repeat (2) @(negedge clk_25m);
        chk("rst mdio_oe", 32'(mdio_oe), 32'd0);
        chk("rst mdio_out", 32'(mdio_out), 32'd1);
        chk("rst pulses", {29'd0, hdr_valid, wr_valid, frame_err}, 32'd0);
        chk("rst legal", 32'(legal), 32'd0);
        chk("rst req", {req_c45, req_op, req_phyad, req_regad, req_wdata}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(i, tv[i]);

        // Open-drain read: the pin is only driven while mdio_out is low.
        opendrain_mode = 1'b1;
        c45_en = 1'b0;
        broadcast_mode = 1'b0;
        resp_en = 1'b1;
        resp_data = 16'h00F0;
        send_frame(32, {2'b01, 2'b10, 5'h05, 5'h02, 2'b10, 16'h0000}, 32, 1'b1);
        repeat (5) @(negedge clk_25m);
        chk("od rdata", 32'(rd_bits(s_out)), 32'h000000F0);
        chk("od oe_bits", 32'(rd_bits(s_oe)), 32'h0000FF0F);
        chk("od ta2_oe", 32'(s_oe[15]), 32'd1);
        opendrain_mode = 1'b0;

        // Reset in the middle of read data: bus released, no late pulses.
        h0 = n_hdr; w0 = n_wr; e0 = n_err;
        send_frame(32, {2'b01, 2'b10, 5'h05, 5'h02, 2'b10, 16'h0000}, 18, 1'b1);
        chk("rstmid oe_before", 32'(mdio_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk_25m);
        chk("rstmid oe", 32'(mdio_oe), 32'd0);
        chk("rstmid legal", 32'(legal), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk_25m);
        chk("rstmid hdr_cnt", n_hdr - h0, 32'd1);
        chk("rstmid err_cnt", n_err - e0, 32'd0);
        chk("rstmid wr_cnt", n_wr - w0, 32'd0);
        chk("rstmid oe_after", 32'(mdio_oe), 32'd0);

        // MDC stops after bit 20 of a read.
        e0 = n_err; w0 = n_wr;
        send_frame(32, {2'b01, 2'b10, 5'h05, 5'h02, 2'b10, 16'h0000}, 21, 1'b1);
        chk("to oe_driving", 32'(mdio_oe), 32'd1);
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_25m);
            cyc++;
            if (frame_err) seen = 1'b1;
        end
        chk("to err_seen", 32'(seen), 32'd1);
        chk("to latency_window", 32'(cyc >= 45 && cyc <= 70), 32'd1);
        @(negedge clk_25m);
        chk("to oe", 32'(mdio_oe), 32'd0);
        chk("to err_cnt", n_err - e0, 32'd1);
        chk("to wr_cnt", n_wr - w0, 32'd0);

        // 31 preamble ones is one short: the frame must be ignored.
        h0 = n_hdr; w0 = n_wr; e0 = n_err; o0 = n_oe;
        send_frame(31, {2'b01, 2'b01, 5'h05, 5'h03, 2'b10, 16'h1357}, 32, 1'b0);
        repeat (5) @(negedge clk_25m);
        chk("pre31 pulses", (n_hdr - h0) + (n_wr - w0) + (n_err - e0), 32'd0);
        chk("pre31 oe", 32'(n_oe > o0), 32'd0);
        chk("pre31 wdata", 32'(req_wdata), 32'd0);

        // Full preamble afterwards is accepted again.
        w0 = n_wr;
        send_frame(32, {2'b01, 2'b01, 5'h05, 5'h03, 2'b10, 16'h1357}, 32, 1'b0);
        repeat (5) @(negedge clk_25m);
        chk("pre32 wr_cnt", n_wr - w0, 32'd1);
        chk("pre32 wdata", 32'(req_wdata), 32'h00001357);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_slave_22_45_frontend_os.md
# mdio_slave_22_45_frontend_os

Oversampled, parametrised MDIO slave frontend for Clause 22 and Clause 45 frames. All logic runs on `clk_25m`. `mdc` and `mdio_in` are synchronised and MDC edges are detected in that domain, which removes the MDC-domain/CDC split of the previous generation. The block adds preamble qualification, a Clause 45 decode, TA drive, a response-late fallback and an MDC-stall timeout. It sits between the pad MDIO and the regmap backend.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `mdc`/`mdio_in` (≥2).
- `PRE_MIN`, 32: consecutive preamble ones required before a start is accepted (0–32; 0 = preamble suppression).
- `TIMEOUT_CYC`, 1024: `clk_25m` cycles without an MDC rise mid-frame before abort (≥16).
- `clk_25m` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: low forces IDLE, releases the bus, clears all state (synchronous).
- `mdc`, `mdio_in` in 1: asynchronous pad inputs.
- `mdio_out`, `mdio_oe` out 1: pad drive.
- `opendrain_mode` in 1: `mdio_oe` = oe_int & ~mdio_out.
- `c45_en` in 1: accept ST=00 frames.
- `phy_addr`, `phy_addr_mask` in 5: legal when (PHYAD & mask) == (phy_addr & mask).
- `broadcast_mode` in 1, `broadcast_addr` in 5: also legal when PHYAD == broadcast_addr.
- `hdr_valid` out 1: 1-cycle pulse, legal read header captured.
- `wr_valid` out 1: 1-cycle pulse, legal write/address frame complete.
- `req_c45` out 1, `req_op` out 2, `req_phyad` out 5, `req_regad` out 5 (DEVAD for C45), `req_wdata` out 16: held from pulse until next frame header.
- `resp_rdata` in 16, `resp_valid` in 1: read data, captured on `resp_valid`.
- `frame_err` out 1: 1-cycle pulse on timeout, late response or illegal ST.
- `legal` out 1: registered address match of the current or last frame.

## Operation
- Synchroniser: mdc_s, mdio_s after SYNC_STAGES flops. rise = mdc_s & ~mdc_d. All bit sampling uses mdio_s on rise.
- FSM states: IDLE, HDR, TA, WDATA, RDATA.
  - IDLE: saturating ones counter pre_cnt (0–32). On rise with bit 0: if pre_cnt ≥ PRE_MIN go to HDR with bit_cnt=1. Otherwise reset pre_cnt and stay. A 1 increments pre_cnt.
- HDR: shift bits 0–13 (ST, OP, PHYAD, REGAD) MSB-first.
  - At bit 13, decode.
  - ST=01 gives C22. Read is OP=10, write is OP=01.
  - ST=00 with c45_en gives C45. Address is OP=00, write is OP=01, read is OP=11, post-read-inc is OP=10.
  - Any other ST pulses frame_err, and the frame is tracked passively to bit 31.
  - Legal read: pulse hdr_valid and go to TA.
  - Otherwise go to TA without driving.
- TA: bits 14–15.
  - Legal read: after the rise sampling bit 14, mdio_oe=1 and mdio_out=0.
  - After the rise sampling bit 15, go to RDATA and load the shifter from the captured response.
  - If no resp_valid has arrived since hdr_valid, load 16'hFFFF and pulse frame_err.
- RDATA: on each rise, present the shifter MSB and shift left. After the rise sampling bit 31, release oe and go to IDLE.
- WDATA: bits 16–31 are shifted into req_wdata. At bit 31, if legal and not a read, pulse wr_valid, then go to IDLE.
- Illegal address or non-read: the frame is tracked to bit 31 with oe=0.
- Timeout: stall counter cleared on every rise and counts in non-IDLE states. On reaching TIMEOUT_CYC: go to IDLE, oe=0, pulse frame_err, no wr_valid.
- pre_cnt is cleared on frame end. Back-to-back frames therefore need PRE_MIN fresh ones.

## Timing
- Reset/enable-low values: FSM IDLE, mdio_oe=0, mdio_out=1, hdr_valid=wr_valid=frame_err=0, legal=0, req_* = 0, pre_cnt=0.
- Rise detect is SYNC_STAGES+1 `clk_25m` after the pad MDC edge.
- Outputs are registered and change in the cycle after rise detect.
- hdr_valid and wr_valid assert the cycle after the rise sampling bit 13 or bit 31 respectively.
- Backend window: resp_valid must assert before the rise sampling bit 15. With MDC ≤ 2.5 MHz this is ≥ 20 `clk_25m` cycles after hdr_valid.
- resp_valid coincident with the bit-15 rise counts as on time.
- resp_valid outside a read window is ignored.
- rst asserted mid-frame: bus released in the same clock, no pulses generated.
- Simultaneous timeout and rise: the rise wins and the counter clears.

## Test plan
- C22 write, PRE=32 ones, PHYAD=phy_addr, REGAD=5'h03, data 16'hA55A -> one wr_valid, req_c45=0, req_op=01, req_regad=03, req_wdata=A55A; mdio_oe never 1.
- C22 read at REGAD=5'h02 with resp_valid/resp_rdata=16'h1234 5 clk after hdr_valid -> TA drives Z then 0; bits 16–31 on mdio_out = 0x1234; oe drops after bit 31.
- C45 address (ST=00, OP=00, DEVAD=1, data 0x0010) then read (OP=11), c45_en=1 -> wr_valid with req_c45=1, req_op=00, req_wdata=0010; read frame gives hdr_valid with req_op=11. Repeat with c45_en=0 -> frame_err, no pulses.
- Read with no resp_valid -> frame_err at the bit-15 rise; mdio_out shifts 0xFFFF.
- Address mismatch with broadcast_mode=1 and PHYAD=broadcast_addr -> legal=1 and normal response. Mismatch with broadcast off -> no pulses, oe=0.
- MDC stops after bit 20 of a read -> TIMEOUT_CYC cycles later frame_err pulses, oe=0, FSM in IDLE. A following frame with only 31 preamble ones (PRE_MIN=32) is ignored.
